// File: rtl/pipe_pkg.sv
// Shared definitions for the 2/3/4-stage core family: register file geometry,
// scoreboard counter width and the bypass mode encoding.
package pipe_pkg;

    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 16;
    localparam int PEND_W   = 3;

    typedef enum logic {
        BYPASS_NONE  = 1'b0,
        BYPASS_FINAL = 1'b1
    } bypassMode_e;

    // A source is hazardous while its pending count exceeds this limit;
    // with final-cycle forwarding a count of 1 can be bypassed.
    function automatic logic [PEND_W-1:0] hazardLimit(input int bypassMode);
        return (bypassMode == int'(BYPASS_FINAL)) ? PEND_W'(1) : PEND_W'(0);
    endfunction

endpackage

// File: rtl/pipe_scoreboard_sat_counter.sv
// Saturating up-counter used for the interlock performance statistics;
// it holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Register scoreboard and interlock controller: tracks in-flight writes,
// stalls decode on RAW/WAW hazards and squashes decode after taken branches.
module pipe_scoreboard #(
    parameter int NUM_REGS   = pipe_pkg::NUM_REGS,
    parameter int REG_AW     = pipe_pkg::REG_AW,
    parameter int WB_LATENCY = 2,
    parameter int BYPASS     = 0,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    input  logic              issue_use_rs1,
    input  logic              issue_use_rs2,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_wb,
    input  logic              branch_taken,
    output logic              stall,
    output logic              flush,
    output logic              issue_accept,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic [CNT_W-1:0]  issue_count
);

    import pipe_pkg::*;

    localparam logic [PEND_W-1:0] WB_LOAD    = PEND_W'(WB_LATENCY);
    localparam logic [PEND_W-1:0] SRC_LIMIT  = hazardLimit(BYPASS);
    localparam logic [2:0]        FLUSH_LOAD = 3'(BR_PENALTY);

    logic [PEND_W-1:0] pend [NUM_REGS];
    logic [2:0]        flushCtr;
    logic              hazardRs1;
    logic              hazardRs2;
    logic              hazardWaw;

    // A pending count above 1 on the destination means an older write would
    // retire after this one, so the newer write must wait.
    assign hazardRs1    = issue_use_rs1 && (pend[issue_rs1] > SRC_LIMIT);
    assign hazardRs2    = issue_use_rs2 && (pend[issue_rs2] > SRC_LIMIT);
    assign hazardWaw    = issue_wb && (pend[issue_rd] > PEND_W'(1));
    assign flush        = (flushCtr != 3'd0);
    assign stall        = issue_valid && !flush && (hazardRs1 || hazardRs2 || hazardWaw);
    assign issue_accept = issue_valid && !stall && !flush;

    for (genvar r = 0; r < NUM_REGS; r++) begin : gSlot
        // A fresh accepted write reloads the slot even while it still counts down.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend[r] <= '0;
            end else if (issue_accept && issue_wb && (issue_rd == REG_AW'(r))) begin
                pend[r] <= WB_LOAD;
            end else if (pend[r] != '0) begin
                pend[r] <= pend[r] - PEND_W'(1);
            end
        end

        assign busy_vec[r] = (pend[r] != '0);
    end

    // A branch resolved during an active flush restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flushCtr <= 3'd0;
        end else if (branch_taken) begin
            flushCtr <= FLUSH_LOAD;
        end else if (flushCtr != 3'd0) begin
            flushCtr <= flushCtr - 3'd1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) uStallCount (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) uFlushCount (
        .clk   (clk),
        .reset (reset),
        .inc   (flush && issue_valid),
        .count (flush_count)
    );

    sat_counter #(.WIDTH(CNT_W)) uIssueCount (
        .clk   (clk),
        .reset (reset),
        .inc   (issue_accept),
        .count (issue_count)
    );

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench: two scoreboards (non-bypass WB=2 and bypass WB=3) share one
// stimulus stream, each checked against hand-derived per-cycle expectations.
module tb_pipe_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       issueValid = 1'b0;
    logic [3:0] issueRs1 = 4'd0;
    logic [3:0] issueRs2 = 4'd0;
    logic       issueUseRs1 = 1'b0;
    logic       issueUseRs2 = 1'b0;
    logic [3:0] issueRd = 4'd0;
    logic       issueWb = 1'b0;
    logic       branchTaken = 1'b0;

    logic        stallA, flushA, acceptA;
    logic [15:0] busyA;
    logic [3:0]  stallCntA, flushCntA, issueCntA;
    logic        stallB, flushB, acceptB;
    logic [15:0] busyB;
    logic [3:0]  stallCntB, flushCntB, issueCntB;

    int vectorCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    pipe_scoreboard #(
        .NUM_REGS(16), .REG_AW(4), .WB_LATENCY(2), .BYPASS(0), .BR_PENALTY(2), .CNT_W(4)
    ) dutA (
        .clk(clk), .reset(reset), .issue_valid(issueValid),
        .issue_rs1(issueRs1), .issue_rs2(issueRs2),
        .issue_use_rs1(issueUseRs1), .issue_use_rs2(issueUseRs2),
        .issue_rd(issueRd), .issue_wb(issueWb), .branch_taken(branchTaken),
        .stall(stallA), .flush(flushA), .issue_accept(acceptA), .busy_vec(busyA),
        .stall_count(stallCntA), .flush_count(flushCntA), .issue_count(issueCntA)
    );

    pipe_scoreboard #(
        .NUM_REGS(16), .REG_AW(4), .WB_LATENCY(3), .BYPASS(1), .BR_PENALTY(2), .CNT_W(4)
    ) dutB (
        .clk(clk), .reset(reset), .issue_valid(issueValid),
        .issue_rs1(issueRs1), .issue_rs2(issueRs2),
        .issue_use_rs1(issueUseRs1), .issue_use_rs2(issueUseRs2),
        .issue_rd(issueRd), .issue_wb(issueWb), .branch_taken(branchTaken),
        .stall(stallB), .flush(flushB), .issue_accept(acceptB), .busy_vec(busyB),
        .stall_count(stallCntB), .flush_count(flushCntB), .issue_count(issueCntB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one decode cycle away from the clock edge; outputs settle 1 ns later.
    task automatic applyStimulus(input logic v, input logic u1, input logic [3:0] r1,
                                 input logic u2, input logic [3:0] r2,
                                 input logic [3:0] rd, input logic wb, input logic br);
        @(negedge clk);
        issueValid  = v;
        issueUseRs1 = u1;
        issueRs1    = r1;
        issueUseRs2 = u2;
        issueRs2    = r2;
        issueRd     = rd;
        issueWb     = wb;
        branchTaken = br;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset       = 1'b1;
        issueValid  = 1'b0;
        issueUseRs1 = 1'b0;
        issueUseRs2 = 1'b0;
        issueWb     = 1'b0;
        branchTaken = 1'b0;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #1;
        checkOutput("rstStallA", 32'(stallA), 32'd0);
        checkOutput("rstFlushA", 32'(flushA), 32'd0);
        checkOutput("rstBusyA", 32'(busyA), 32'd0);
        checkOutput("rstCntA", 32'({stallCntA, flushCntA, issueCntA}), 32'd0);
        checkOutput("rstBusyB", 32'(busyB), 32'd0);

        // RAW on r1: non-bypass stalls two cycles, bypass accepts at pend==1
        doReset();
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd1, 1, 0);
        checkOutput("rawAcc0A", 32'(acceptA), 32'd1);
        checkOutput("rawAcc0B", 32'(acceptB), 32'd1);
        applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("rawStall1A", 32'(stallA), 32'd1);
        checkOutput("rawStall1B", 32'(stallB), 32'd1);
        checkOutput("rawBusy1A", 32'(busyA), 32'h0002);
        applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("rawStall2A", 32'(stallA), 32'd1);
        checkOutput("rawStall2B", 32'(stallB), 32'd1);
        applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("rawAcc3A", 32'(acceptA), 32'd1);
        checkOutput("rawAcc3B", 32'(acceptB), 32'd1);
        checkOutput("rawStallCntA", 32'(stallCntA), 32'd2);
        checkOutput("rawStallCntB", 32'(stallCntB), 32'd2);
        checkOutput("rawBusy3A", 32'(busyA), 32'h0000);
        checkOutput("rawBusy3B", 32'(busyB), 32'h0002);

        // Taken branch, then a second one inside the window
        doReset();
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd0, 0, 1);
        checkOutput("brSameCycFlushA", 32'(flushA), 32'd0);
        checkOutput("brSameCycAccA", 32'(acceptA), 32'd1);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd0, 0, 1);
        checkOutput("brFlush1A", 32'(flushA), 32'd1);
        checkOutput("brAcc1A", 32'(acceptA), 32'd0);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("brFlush2A", 32'(flushA), 32'd1);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("brFlush3B", 32'(flushB), 32'd1);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("brEndFlushA", 32'(flushA), 32'd0);
        checkOutput("brEndAccA", 32'(acceptA), 32'd1);
        checkOutput("brFlushCntA", 32'(flushCntA), 32'd3);
        checkOutput("brFlushCntB", 32'(flushCntB), 32'd3);
        checkOutput("brIssueCntA", 32'(issueCntA), 32'd1);

        // Hazard on r3 while squashing: no stall, no scoreboard update
        doReset();
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd3, 1, 1);
        checkOutput("hfAcc0A", 32'(acceptA), 32'd1);
        applyStimulus(1, 1, 4'd3, 0, 4'd0, 4'd5, 1, 0);
        checkOutput("hfFlushA", 32'(flushA), 32'd1);
        checkOutput("hfStallA", 32'(stallA), 32'd0);
        checkOutput("hfStallB", 32'(stallB), 32'd0);
        checkOutput("hfAccA", 32'(acceptA), 32'd0);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("hfBusyA", 32'(busyA), 32'h0008);
        checkOutput("hfBusyB", 32'(busyB), 32'h0008);
        checkOutput("hfStallCntA", 32'(stallCntA), 32'd0);
        checkOutput("hfFlushCntA", 32'(flushCntA), 32'd1);

        // WAW on r4
        doReset();
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd4, 1, 0);
        checkOutput("wawAcc0B", 32'(acceptB), 32'd1);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd4, 1, 0);
        checkOutput("wawStall1A", 32'(stallA), 32'd1);
        checkOutput("wawStall1B", 32'(stallB), 32'd1);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd4, 1, 0);
        checkOutput("wawAcc2A", 32'(acceptA), 32'd1);
        checkOutput("wawStall2B", 32'(stallB), 32'd1);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd4, 1, 0);
        checkOutput("wawStall3A", 32'(stallA), 32'd1);
        checkOutput("wawAcc3B", 32'(acceptB), 32'd1);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("wawBusy4A", 32'(busyA), 32'h0010);
        checkOutput("wawBusy4B", 32'(busyB), 32'h0010);
        checkOutput("wawStallCntA", 32'(stallCntA), 32'd2);
        checkOutput("wawStallCntB", 32'(stallCntB), 32'd2);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("wawBusy6A", 32'(busyA), 32'h0000);
        checkOutput("wawBusy6B", 32'(busyB), 32'h0010);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("wawBusy7B", 32'(busyB), 32'h0000);

        // Asynchronous reset between edges while stalled
        doReset();
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 4'd1, 1, 0);
        applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd0, 0, 0);
        applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("arPreStallCntA", 32'(stallCntA), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("arStallA", 32'(stallA), 32'd0);
        checkOutput("arBusyA", 32'(busyA), 32'h0000);
        checkOutput("arBusyB", 32'(busyB), 32'h0000);
        checkOutput("arStallCntA", 32'(stallCntA), 32'd0);
        checkOutput("arIssueCntA", 32'(issueCntA), 32'd0);
        reset = 1'b0;
        applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd0, 0, 0);
        checkOutput("arCleanAccA", 32'(acceptA), 32'd1);

        // Self-dependent write: stall, stall, accept repeating until saturation
        doReset();
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd1, 1, 0);
        end
        applyStimulus(1, 1, 4'd1, 0, 4'd0, 4'd1, 1, 0);
        checkOutput("satStallCntA", 32'(stallCntA), 32'd15);
        checkOutput("satStallCntB", 32'(stallCntB), 32'd15);
        checkOutput("satIssueCntA", 32'(issueCntA), 32'd11);
        checkOutput("satIssueCntB", 32'(issueCntB), 32'd11);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
